// File: rtl/keccak_pkg.sv
// Shared constants, state type and pad bytes for the 32-bit Keccak padder.
// Define KECCAK_PADDER_SHA3_DOMAIN_EN to pad with the SHA3 domain byte 0x06 instead of 0x01.
package keccak_pkg;

  localparam int unsigned RATE   = 576;
  localparam int unsigned W      = 32;
  localparam int unsigned NWORDS = RATE / W;

  // Index of the last word in a block; the final-bit marker lands here.
  localparam logic [4:0] LAST_IDX = 5'(NWORDS - 1);

  typedef enum logic [1:0] {
    ACCUM,
    PAD,
    FULL,
    DONE
  } state_e;

`ifdef KECCAK_PADDER_SHA3_DOMAIN_EN
  localparam logic [7:0] PAD_BYTE = 8'h06;
`else
  localparam logic [7:0] PAD_BYTE = 8'h01;
`endif

  localparam logic [7:0] FINAL_BYTE = 8'h80;

endpackage

// File: rtl/keccak_pad_word.sv
// Combinational padding of one 32-bit word: keeps byte_num data bytes (big-endian),
// inserts the pad byte after them, zeroes the rest and ORs in the final-bit marker.
module keccak_pad_word
  import keccak_pkg::*;
(
  input  logic [W-1:0] word_i,
  input  logic [1:0]   byte_num_i,
  input  logic         pad_en_i,
  input  logic         is_final_word_i,
  output logic [W-1:0] word_o
);

  always_comb begin
    word_o = word_i;
    if (pad_en_i) begin
      // Byte k occupies bits [31-8k -: 8], so byte 0 is the most significant.
      for (int k = 0; k < 4; k++) begin
        if (k == int'(byte_num_i)) begin
          word_o[31-8*k -: 8] = PAD_BYTE;
        end else if (k > int'(byte_num_i)) begin
          word_o[31-8*k -: 8] = 8'h00;
        end
      end
    end
    if (is_final_word_i) begin
      word_o[7:0] = word_o[7:0] | FINAL_BYTE;
    end
  end

endmodule

// File: rtl/keccak_padder32.sv
// Packs 32-bit message words into 576-bit rate blocks and applies Keccak multi-rate padding.
// Build option: KECCAK_PADDER_SHA3_DOMAIN_EN selects the SHA3 pad byte (see keccak_pkg).
module keccak_padder32
  import keccak_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [W-1:0]    in,
  input  logic            in_ready,
  input  logic            is_last,
  input  logic [1:0]      byte_num,
  output logic            buffer_full,
  output logic [RATE-1:0] out,
  output logic            out_ready,
  input  logic            f_ack
);

  state_e          state_q, state_d;
  logic [4:0]      i_q, i_d;
  logic [RATE-1:0] out_q, out_d;
  logic            padded_q, padded_d;

  logic [W-1:0]    pw_in;
  logic            pw_pad_en;
  logic            pw_final;
  logic [W-1:0]    pw_word;

  // PAD state feeds zeros through the same padder so only the marker can appear.
  always_comb begin
    pw_in     = (state_q == PAD) ? '0 : in;
    pw_pad_en = (state_q == ACCUM) && is_last;
    pw_final  = (i_q == LAST_IDX) && ((state_q == PAD) || is_last);
  end

  keccak_pad_word u_pad_word (
    .word_i          (pw_in),
    .byte_num_i      (byte_num),
    .pad_en_i        (pw_pad_en),
    .is_final_word_i (pw_final),
    .word_o          (pw_word)
  );

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    out_d    = out_q;
    padded_d = padded_q;
    unique case (state_q)
      ACCUM: begin
        if (in_ready) begin
          out_d = {out_q[RATE-W-1:0], pw_word};
          i_d   = i_q + 5'd1;
          if (is_last) begin
            padded_d = 1'b1;
          end
          if (i_q == LAST_IDX) begin
            state_d = FULL;
          end else if (is_last) begin
            state_d = PAD;
          end
        end
      end
      PAD: begin
        out_d = {out_q[RATE-W-1:0], pw_word};
        i_d   = i_q + 5'd1;
        if (i_q == LAST_IDX) begin
          state_d = FULL;
        end
      end
      FULL: begin
        // The permutation samples out during the ack cycle; no word is taken here.
        if (f_ack) begin
          i_d     = '0;
          state_d = padded_q ? DONE : ACCUM;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ACCUM;
      i_q      <= '0;
      out_q    <= '0;
      padded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      out_q    <= out_d;
      padded_q <= padded_d;
    end
  end

  assign out         = out_q;
  assign out_ready   = (state_q == FULL);
  assign buffer_full = (state_q != ACCUM);

endmodule

// File: tb/tb_keccak_padder32.sv
// Directed self-checking bench for keccak_padder32 with hand-computed expected blocks.
module tb_keccak_padder32;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  in;
  logic         in_ready;
  logic         is_last;
  logic [1:0]   byte_num;
  logic         buffer_full;
  logic [575:0] out;
  logic         out_ready;
  logic         f_ack;

  int n_vec = 0;
  int n_err = 0;

`ifdef KECCAK_PADDER_SHA3_DOMAIN_EN
  localparam logic [7:0] PB = 8'h06;
`else
  localparam logic [7:0] PB = 8'h01;
`endif

  keccak_padder32 dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
    .in_ready    (in_ready),
    .is_last     (is_last),
    .byte_num    (byte_num),
    .buffer_full (buffer_full),
    .out         (out),
    .out_ready   (out_ready),
    .f_ack       (f_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_ready = 1'b0;
    is_last = 1'b0;
    f_ack = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int exp_cycles);
    int n = 0;
    while (!out_ready && n < 40) begin
      tick();
      n++;
    end
    check(tag, 576'(n), 576'(exp_cycles));
  endtask

  task automatic send_empty();
    in = 32'hDEADBEEF;
    is_last = 1'b1;
    byte_num = 2'd0;
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    is_last = 1'b0;
  endtask

  logic [575:0] exp_blk;
  logic [575:0] hold;

  initial begin
    in = '0;
    byte_num = '0;
    do_reset();
    tick();
    check("rst_out", out, '0);
    check("rst_ordy", 576'(out_ready), 576'(0));
    check("rst_bfull", 576'(buffer_full), 576'(0));

    // Empty message
    exp_blk = '0;
    exp_blk[575:544] = {PB, 24'h0};
    exp_blk[31:0] = 32'h80;
    send_empty();
    check("empty_pad_bfull", 576'(buffer_full), 576'(1));
    check("empty_pad_ordy", 576'(out_ready), 576'(0));
    wait_ready("empty_lat", 17);
    check("empty_blk", out, exp_blk);
    check("empty_bfull", 576'(buffer_full), 576'(1));
    f_ack = 1'b1;
    tick();
    f_ack = 1'b0;
    check("done_ordy", 576'(out_ready), 576'(0));
    check("done_bfull", 576'(buffer_full), 576'(1));
    in = 32'h12345678;
    in_ready = 1'b1;
    tick();
    tick();
    in_ready = 1'b0;
    check("done_ignore", out, exp_blk);

    // 18 full words, back-pressure, then a lone is_last word
    do_reset();
    exp_blk = '0;
    for (int k = 0; k < 18; k++) begin
      in = 32'(k + 1);
      in_ready = 1'b1;
      exp_blk[575-32*k -: 32] = 32'(k + 1);
      tick();
    end
    check("blk1_ordy", 576'(out_ready), 576'(1));
    check("blk1", out, exp_blk);
    check("blk1_w0", 576'(out[575:544]), 576'(32'h1));
    check("blk1_w17", 576'(out[31:0]), 576'(32'h12));
    in = 32'hCAFEF00D;
    is_last = 1'b1;
    byte_num = 2'd0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_out", out, exp_blk);
      check("bp_bfull", 576'(buffer_full), 576'(1));
    end
    f_ack = 1'b1;
    tick();
    f_ack = 1'b0;
    check("ack_noaccept", out, exp_blk);
    check("ack_ordy", 576'(out_ready), 576'(0));
    check("ack_bfull", 576'(buffer_full), 576'(0));
    tick();
    in_ready = 1'b0;
    is_last = 1'b0;
    check("blk2_first", 576'(out[31:0]), 576'({PB, 24'h0}));
    wait_ready("blk2_lat", 17);
    exp_blk = '0;
    exp_blk[575:544] = {PB, 24'h0};
    exp_blk[31:0] = 32'h80;
    check("blk2", out, exp_blk);
    f_ack = 1'b1;
    tick();
    f_ack = 1'b0;
    check("blk2_done", 576'(buffer_full), 576'(1));

    // Last word at index 17 with three data bytes
    do_reset();
    exp_blk = '0;
    for (int k = 0; k < 17; k++) begin
      in = 32'h100 + 32'(k);
      in_ready = 1'b1;
      exp_blk[575-32*k -: 32] = 32'h100 + 32'(k);
      tick();
    end
    check("i17_not_ready", 576'(out_ready), 576'(0));
    in = 32'hAABBCCDD;
    is_last = 1'b1;
    byte_num = 2'd3;
    tick();
    in_ready = 1'b0;
    is_last = 1'b0;
    exp_blk[31:0] = {24'hAABBCC, PB | 8'h80};
    check("i17_ordy", 576'(out_ready), 576'(1));
    check("i17_blk", out, exp_blk);

    // Partial last words
    do_reset();
    in = 32'h12345678;
    is_last = 1'b1;
    byte_num = 2'd2;
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    check("bn2_word", 576'(out[31:0]), 576'({16'h1234, PB, 8'h00}));
    do_reset();
    in = 32'h9ABCDEF0;
    is_last = 1'b1;
    byte_num = 2'd1;
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    check("bn1_word", 576'(out[31:0]), 576'({8'h9A, PB, 16'h0}));

    // Reset during PAD at i=9
    do_reset();
    send_empty();
    for (int k = 0; k < 8; k++) tick();
    hold = out;
    check("mid_pad_state", 576'(buffer_full), 576'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_out", out, '0);
    check("mid_rst_ordy", 576'(out_ready), 576'(0));
    check("mid_rst_bfull", 576'(buffer_full), 576'(0));
    exp_blk = '0;
    exp_blk[575:544] = {PB, 24'h0};
    exp_blk[31:0] = 32'h80;
    send_empty();
    wait_ready("rerun_lat", 17);
    check("rerun_blk", out, exp_blk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
